// File: rtl/alu_pkg.sv
// Shared EX-stage ALU definitions: ALUControl op encodings and the multiply sequencer state type.
package alu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_MULT = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b00100;
  localparam logic [4:0] ALU_OR   = 5'b00101;
  localparam logic [4:0] ALU_NOR  = 5'b00110;
  localparam logic [4:0] ALU_XOR  = 5'b00111;
  localparam logic [4:0] ALU_SLL  = 5'b01000;
  localparam logic [4:0] ALU_SRL  = 5'b01001;
  localparam logic [4:0] ALU_SLT  = 5'b01010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mult_state_e;

endpackage

// File: rtl/mult_shift_add.sv
// Radix-2 shift-add datapath: holds |A|, |B| and the partial product, one step per enable.
module mult_shift_add #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic [WIDTH-1:0] acc_next,
  output logic             exhausted
);

  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mplier_next_s;

  // Partial product after this cycle's step; also feeds the final result capture
  always_comb begin
    mplier_next_s = {1'b0, mplier_r[WIDTH-1:1]};
    if (mplier_r[0]) begin
      acc_next = acc_r + mcand_r;
    end else begin
      acc_next = acc_r;
    end
    exhausted = EARLY_EXIT & (mplier_next_s == {WIDTH{1'b0}});
  end

  // Operand latch on load, one add-shift step per enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
    end else if (load) begin
      mcand_r  <= mcand_in;
      mplier_r <= mplier_in;
      acc_r    <= {WIDTH{1'b0}};
    end else if (step) begin
      mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
      mplier_r <= mplier_next_s;
      acc_r    <= acc_next;
    end else begin
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      acc_r    <= acc_r;
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// EX-stage iterative signed multiply sequencer; stalls the pipeline until the product is ready.
// Define MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module mult_sequencer
  import alu_pkg::*;
#(
  parameter int         WIDTH   = 32,
  parameter logic [4:0] MULT_OP = ALU_MULT
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       ALUControl,
  input  logic             Valid,
  input  logic             ExHold,
  input  logic             Flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`ifdef MULT_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    abs_val = x[WIDTH-1] ? ({WIDTH{1'b0}} - x) : x;
  endfunction

  mult_state_e      state_r, next_state_s;
  logic [CW-1:0]    count_r;
  logic             sign_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             start_s;
  logic             skip_run_s;
  logic             last_step_s;
  logic [WIDTH-1:0] a_abs_s;
  logic [WIDTH-1:0] b_abs_s;
  logic [WIDTH-1:0] acc_next_s;
  logic             exhausted_s;

  mult_shift_add #(
    .WIDTH      (WIDTH),
    .EARLY_EXIT (EARLY_EXIT)
  ) u_shift_add (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .load      (start_s),
    .step      (state_r == RUN),
    .mcand_in  (a_abs_s),
    .mplier_in (b_abs_s),
    .acc_next  (acc_next_s),
    .exhausted (exhausted_s)
  );

  // Start detection and next-state decode; Flush outranks ExHold everywhere
  always_comb begin
    a_abs_s      = abs_val(A);
    b_abs_s      = abs_val(B);
    start_s      = (state_r == IDLE) & Valid & ~Flush & (ALUControl == MULT_OP);
    skip_run_s   = EARLY_EXIT & (b_abs_s == {WIDTH{1'b0}});
    last_step_s  = (count_r == LAST_CNT) | exhausted_s;
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          next_state_s = skip_run_s ? DONE : RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (Flush) begin
          next_state_s = IDLE;
        end else if (last_step_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        if (Flush) begin
          next_state_s = IDLE;
        end else if (ExHold) begin
          next_state_s = DONE;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Step counter, latched sign, status flags and sign-corrected result capture
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_r  <= {CW{1'b0}};
      sign_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {WIDTH{1'b0}};
    end else begin
      busy_r <= (next_state_s == RUN);
      done_r <= (next_state_s == DONE);
      if (start_s) begin
        count_r <= {CW{1'b0}};
        sign_r  <= A[WIDTH-1] ^ B[WIDTH-1];
      end else if (state_r == RUN) begin
        count_r <= count_r + CW'(1);
        sign_r  <= sign_r;
      end else begin
        count_r <= count_r;
        sign_r  <= sign_r;
      end
      if (start_s && skip_run_s) begin
        result_r <= {WIDTH{1'b0}};
      end else if ((state_r == RUN) && !Flush && last_step_s) begin
        result_r <= sign_r ? ({WIDTH{1'b0}} - acc_next_s) : acc_next_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign Stall  = start_s | (state_r == RUN);
  assign Busy   = busy_r;
  assign Done   = done_r;
  assign Result = result_r;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed table, corner sequences and randomized products.
module tb_mult_sequencer;
  import alu_pkg::*;

  localparam int W = 32;
`ifdef MULT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic [4:0]    ALUControl = ALU_ADD;
  logic          Valid = 1'b0;
  logic          ExHold = 1'b0;
  logic          Flush = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          Stall, Busy, Done;
  logic [W-1:0]  Result;

  int            errors = 0;
  int            checks = 0;
  logic [W-1:0]  last_exp = '0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  mult_sequencer #(.WIDTH(W), .MULT_OP(ALU_MULT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ALUControl(ALUControl), .Valid(Valid),
    .ExHold(ExHold), .Flush(Flush), .A(A), .B(B),
    .Stall(Stall), .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: low 32 bits of the true signed product
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  // Cycles from start to Done: fixed, or (msb index of |B|)+2 with early exit
  function automatic int exp_latency(input logic [31:0] b);
    logic [31:0] m;
    int idx;
    m = b[31] ? (32'd0 - b) : b;
    idx = -1;
    for (int i = 0; i < 32; i++) if (m[i]) idx = i;
    if (!EARLY) return W + 1;
    if (idx < 0) return 1;
    return idx + 2;
  endfunction

  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
    int n, stalls, lat;
    logic seen;
    lat = exp_latency(b);
    @(negedge Clk);
    A = a; B = b; ALUControl = ALU_MULT; Valid = 1'b1;
    #1 check({name, " start_stall"}, Stall, 1);
    stalls = Stall ? 1 : 0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge Clk);
      n++;
      @(negedge Clk);
      if (Done) seen = 1'b1;
      else if (Stall) stalls++;
      A = $urandom;
      B = $urandom;
    end
    check({name, " latency"}, n, lat);
    check({name, " stall_cycles"}, stalls, lat);
    check({name, " result"}, Result, exp);
    check({name, " stall_in_done"}, Stall, 0);
    check({name, " busy_in_done"}, Busy, 0);
    Valid = 1'b0;
    ALUControl = ALU_ADD;
    @(negedge Clk);
    check({name, " done_drop"}, Done, 0);
    last_exp = exp;
  endtask

  initial begin
    int n;
    vecs[0] = '{32'd7,         32'd6,         32'd42};
    vecs[1] = '{32'hFFFFFFFD,  32'd5,         32'hFFFFFFF1};
    vecs[2] = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000};
    vecs[3] = '{32'd0,         32'd12345,     32'd0};
    vecs[4] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1};
    vecs[5] = '{32'h7FFFFFFF,  32'd2,         32'hFFFFFFFE};
    vecs[6] = '{32'h80000000,  32'h80000000,  32'd0};
    vecs[7] = '{32'd12345,     32'hFFFFFC18,  32'hFF43A158};
    vecs[8] = '{32'd5,         32'd0,         32'd0};
    vecs[9] = '{32'd3,         32'd3,         32'd9};

    // Reset state
    #12;
    check("rst_stall", Stall, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_result", Result, 0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Non-mult ops and suppressed starts never stall
    ALUControl = ALU_ADD; Valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      check("add_stall", Stall, 0);
      check("add_busy", Busy, 0);
      check("add_done", Done, 0);
    end
    ALUControl = ALU_MULT; Valid = 1'b0;
    #1 check("bubble_stall", Stall, 0);
    Valid = 1'b1; Flush = 1'b1;
    #1 check("flush_idle_stall", Stall, 0);
    @(negedge Clk);
    check("flush_idle_busy", Busy, 0);
    Flush = 1'b0; Valid = 1'b0; ALUControl = ALU_ADD;

    for (int i = 0; i < 10; i++) do_mult(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // Flush ten cycles into RUN: abort, no Done, Result unchanged
    @(negedge Clk);
    A = 32'd5; B = 32'h40000005; ALUControl = ALU_MULT; Valid = 1'b1;
    repeat (10) @(negedge Clk);
    Flush = 1'b1;
    #1 check("flush_run_busy_before", Busy, 1);
    @(negedge Clk);
    check("flush_run_busy_after", Busy, 0);
    check("flush_run_result", Result, last_exp);
    Flush = 1'b0; Valid = 1'b0; ALUControl = ALU_ADD;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check("flush_run_no_done", Done, 0);
    end

    // Completion under ExHold: held, no restart, then Flush beats ExHold
    @(negedge Clk);
    A = 32'hFFFFFFF7; B = 32'd11; ALUControl = ALU_MULT; Valid = 1'b1;
    n = 0;
    while (!Done && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("hold_reached_done", Done, 1);
    ExHold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check("hold_done", Done, 1);
      check("hold_result", Result, 32'hFFFFFF9D);
      check("hold_no_restart", Stall, 0);
      check("hold_busy", Busy, 0);
    end
    Flush = 1'b1;
    @(negedge Clk);
    check("flush_done_drop", Done, 0);
    check("flush_done_busy", Busy, 0);
    Flush = 1'b0; ExHold = 1'b0; Valid = 1'b0; ALUControl = ALU_ADD;
    last_exp = 32'hFFFFFF9D;

    // Asynchronous reset in the middle of RUN
    @(negedge Clk);
    A = 32'd100; B = 32'h00100003; ALUControl = ALU_MULT; Valid = 1'b1;
    repeat (5) @(negedge Clk);
    check("midrst_busy_before", Busy, 1);
    Rst_n = 1'b0; Valid = 1'b0; ALUControl = ALU_ADD;
    #1;
    check("midrst_busy", Busy, 0);
    check("midrst_done", Done, 0);
    check("midrst_result", Result, 0);
    check("midrst_stall", Stall, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    do_mult(32'd7, 32'd6, 32'd42, "post_rst");

    // Randomized operands against the arithmetic reference
    for (int i = 0; i < 20; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = 32'($urandom_range(0, 31)) - 32'd16;
      if (i % 5 == 1) ra = 32'h80000000;
      do_mult(ra, rb, model(ra, rb), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
